// File: rtl/multi_cycle_ctrl_if.sv
// Control interface between the multi-cycle controller and its datapath.
//
// Purpose: bundles the instruction fields and ALU zero flag that feed the
// controller together with every mux select, write enable and debug signal it
// drives back into the datapath.
//
// Modports:
//   master - controller side: samples op/funct/zero, drives all controls
//   slave  - datapath side: drives op/funct/zero, samples all controls
//
// Signals:
//   op[5:0]          instr[31:26] from the instruction register
//   funct[5:0]       instr[5:0] from the instruction register
//   zero             ALU zero flag
//   alu_control[2:0] ALU operation code
//   alu_src_a        0: PC, 1: reg A
//   alu_src_b[1:0]   00: reg B, 01: const 4, 10: ext imm, 11: sign-ext imm<<2
//   ext_op           1: sign-extend imm, 0: zero-extend
//   i_or_d           memory address mux; 0: PC, 1: ALUOut
//   ir_write         load instruction register
//   mem_write        data memory write enable
//   reg_write        register file write enable
//   reg_dst          1: rd, 0: rt
//   mem_to_reg       1: MDR, 0: ALUOut
//   pc_en            PC write enable
//   pc_source[1:0]   00: ALU result, 01: ALUOut, 10: jump target
//   illegal          one-cycle pulse on an unsupported op/funct
//   state[3:0]       current controller state, for debug
interface multi_cycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_op;
  logic       i_or_d;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       pc_en;
  logic [1:0] pc_source;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, funct, zero,
    output alu_control, alu_src_a, alu_src_b, ext_op, i_or_d, ir_write, mem_write,
           reg_write, reg_dst, mem_to_reg, pc_en, pc_source, illegal, state
  );

  modport slave (
    output op, funct, zero,
    input  alu_control, alu_src_a, alu_src_b, ext_op, i_or_d, ir_write, mem_write,
           reg_write, reg_dst, mem_to_reg, pc_en, pc_source, illegal, state
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle datapath controller.
//
// Purpose: Moore FSM that steps each instruction through fetch, decode,
// execute, memory and write-back, producing the ALU control word, all datapath
// mux selects and all write enables. The ALU zero flag comes back in to
// qualify the PC write for beq.
//
// Ports:
//   clk      in  rising-edge clock
//   reset_n  in  asynchronous active-low reset; forces FETCH and zeroes every
//                control output (state reads 0) while low
//   io_ctrl  multi_cycle_ctrl_if.master, instruction fields in, controls out
//   retired  out [CNT_W-1:0] retired-instruction count (PERF_CNT_EN only)
//
// Configuration macro:
//   PERF_CNT_EN - adds the CNT_W parameter, the retired output and a wrapping
//                 counter that steps on the last cycle of every legal
//                 instruction. Without it neither port nor logic exists.
module multi_cycle_ctrl
`ifdef PERF_CNT_EN
#(
  parameter int unsigned CNT_W = 32
)
`endif
(
  input  logic                clk,
  input  logic                reset_n,
  multi_cycle_ctrl_if.master  io_ctrl
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    retired
`endif
);

  // ALU control codes; 011/100/101/111 are never produced.
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FnAddu  = 6'b100001;
  localparam logic [5:0] FnSubu  = 6'b100011;
  localparam logic [5:0] FnAnd   = 6'b100100;
  localparam logic [5:0] FnOr    = 6'b100101;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StRtExec = 4'd6,
    StRtWb   = 4'd7,
    StBranch = 4'd8,
    StIExec  = 4'd9,
    StIWb    = 4'd10,
    StJump   = 4'd11
  } state_e;

  state_e r_state;
  state_e w_state_d;

  // Remembers lw vs sw across MEMADR so op is only looked at in DECODE.
  logic r_is_lw;
  logic w_is_lw_d;

  // Opcode / funct decode.
  logic       w_op_legal;
  logic       w_funct_ok;
  logic [2:0] w_rt_alu;

  always_comb begin
    w_op_legal = 1'b0;
    unique case (io_ctrl.op)
      OpRType, OpLw, OpSw, OpBeq, OpOri, OpJ: w_op_legal = 1'b1;
      default:                                w_op_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_funct_ok = 1'b1;
    w_rt_alu   = ALU_ADD;
    unique case (io_ctrl.funct)
      FnAddu: w_rt_alu = ALU_ADD;
      FnSubu: w_rt_alu = ALU_SUB;
      FnAnd:  w_rt_alu = ALU_AND;
      FnOr:   w_rt_alu = ALU_OR;
      default: begin
        // Unknown R-type funct: harmless add, no write-back.
        w_rt_alu   = ALU_ADD;
        w_funct_ok = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StFetch;
      r_is_lw <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_is_lw <= w_is_lw_d;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    w_is_lw_d = r_is_lw;
    case (r_state)
      StFetch:  w_state_d = StDecode;
      StDecode: begin
        unique case (io_ctrl.op)
          OpLw: begin
            w_state_d = StMemAdr;
            w_is_lw_d = 1'b1;
          end
          OpSw: begin
            w_state_d = StMemAdr;
            w_is_lw_d = 1'b0;
          end
          OpRType: w_state_d = StRtExec;
          OpBeq:   w_state_d = StBranch;
          OpOri:   w_state_d = StIExec;
          OpJ:     w_state_d = StJump;
          default: w_state_d = StFetch;
        endcase
      end
      StMemAdr: w_state_d = r_is_lw ? StMemRd : StMemWr;
      StMemRd:  w_state_d = StMemWb;
      StRtExec: w_state_d = w_funct_ok ? StRtWb : StFetch;
      StIExec:  w_state_d = StIWb;
      // MEMWB, MEMWR, RTWB, IWB, BRANCH, JUMP and unused encodings.
      default:  w_state_d = StFetch;
    endcase
  end

  // Output logic.
  logic [2:0] w_alu_control;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic       w_ext_op;
  logic       w_i_or_d;
  logic       w_ir_write;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic       w_pc_en;
  logic [1:0] w_pc_source;
  logic       w_illegal;

  always_comb begin
    w_alu_control = ALU_AND;
    w_alu_src_a   = 1'b0;
    w_alu_src_b   = 2'b00;
    w_ext_op      = 1'b0;
    w_i_or_d      = 1'b0;
    w_ir_write    = 1'b0;
    w_mem_write   = 1'b0;
    w_reg_write   = 1'b0;
    w_reg_dst     = 1'b0;
    w_mem_to_reg  = 1'b0;
    w_pc_en       = 1'b0;
    w_pc_source   = 2'b00;
    w_illegal     = 1'b0;
    // Gate on reset_n so FETCH's enables never leak out while held in reset.
    if (reset_n) begin
      case (r_state)
        StFetch: begin
          w_ir_write    = 1'b1;
          w_alu_src_b   = 2'b01;
          w_alu_control = ALU_ADD;
          w_pc_en       = 1'b1;
        end
        StDecode: begin
          // Precompute the branch target into ALUOut.
          w_alu_src_b   = 2'b11;
          w_alu_control = ALU_ADD;
          w_illegal     = ~w_op_legal;
        end
        StMemAdr: begin
          w_alu_src_a   = 1'b1;
          w_alu_src_b   = 2'b10;
          w_ext_op      = 1'b1;
          w_alu_control = ALU_ADD;
        end
        StMemRd: w_i_or_d = 1'b1;
        StMemWr: begin
          w_i_or_d    = 1'b1;
          w_mem_write = 1'b1;
        end
        StMemWb: begin
          w_reg_write  = 1'b1;
          w_mem_to_reg = 1'b1;
        end
        StRtExec: begin
          w_alu_src_a   = 1'b1;
          w_alu_control = w_rt_alu;
          w_illegal     = ~w_funct_ok;
        end
        StRtWb: begin
          w_reg_write = 1'b1;
          w_reg_dst   = 1'b1;
        end
        StBranch: begin
          w_alu_src_a   = 1'b1;
          w_alu_control = ALU_SUB;
          w_pc_source   = 2'b01;
          w_pc_en       = io_ctrl.zero;
        end
        StIExec: begin
          w_alu_src_a   = 1'b1;
          w_alu_src_b   = 2'b10;
          w_alu_control = ALU_OR;
        end
        StIWb: w_reg_write = 1'b1;
        StJump: begin
          w_pc_source = 2'b10;
          w_pc_en     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign io_ctrl.alu_control = w_alu_control;
  assign io_ctrl.alu_src_a   = w_alu_src_a;
  assign io_ctrl.alu_src_b   = w_alu_src_b;
  assign io_ctrl.ext_op      = w_ext_op;
  assign io_ctrl.i_or_d      = w_i_or_d;
  assign io_ctrl.ir_write    = w_ir_write;
  assign io_ctrl.mem_write   = w_mem_write;
  assign io_ctrl.reg_write   = w_reg_write;
  assign io_ctrl.reg_dst     = w_reg_dst;
  assign io_ctrl.mem_to_reg  = w_mem_to_reg;
  assign io_ctrl.pc_en       = w_pc_en;
  assign io_ctrl.pc_source   = w_pc_source;
  assign io_ctrl.illegal     = w_illegal;
  assign io_ctrl.state       = r_state;

`ifdef PERF_CNT_EN
  logic             w_retire;
  logic [CNT_W-1:0] r_retired;

  // Last cycle of every legal instruction; an illegal R-type funct leaves
  // from RTEXEC and is therefore not counted.
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      StMemWb, StMemWr, StRtWb, StIWb, StBranch, StJump: w_retire = 1'b1;
      default:                                           w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign retired = r_retired;
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
module tb_multi_cycle_ctrl;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  multi_cycle_ctrl_if bus ();

`ifdef PERF_CNT_EN
  logic [3:0] retired;
  multi_cycle_ctrl #(.CNT_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io_ctrl (bus),
    .retired (retired)
  );
`else
  multi_cycle_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io_ctrl (bus)
  );
`endif

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] alu;
    logic       src_a;
    logic [1:0] src_b;
    logic       ext;
    logic       iord;
    logic       irw;
    logic       memw;
    logic       regw;
    logic       regdst;
    logic       m2r;
    logic       pcen;
    logic [1:0] pcs;
    logic       ill;
  } out_t;

  out_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Expected controls for one state, straight from the per-state table.
  function automatic out_t exp_state(input logic [3:0] st, input logic [2:0] rt_alu,
                                     input logic z, input logic ill);
    out_t e;
    e    = '0;
    e.st = st;
    case (st)
      4'd0:  begin e.irw = 1; e.src_b = 2'b01; e.alu = 3'b010; e.pcen = 1; end
      4'd1:  begin e.src_b = 2'b11; e.alu = 3'b010; e.ill = ill; end
      4'd2:  begin e.src_a = 1; e.src_b = 2'b10; e.ext = 1; e.alu = 3'b010; end
      4'd3:  e.iord = 1;
      4'd4:  begin e.regw = 1; e.m2r = 1; end
      4'd5:  begin e.iord = 1; e.memw = 1; end
      4'd6:  begin e.src_a = 1; e.alu = rt_alu; e.ill = ill; end
      4'd7:  begin e.regw = 1; e.regdst = 1; end
      4'd8:  begin e.src_a = 1; e.alu = 3'b110; e.pcs = 2'b01; e.pcen = z; end
      4'd9:  begin e.src_a = 1; e.src_b = 2'b10; e.alu = 3'b001; end
      4'd10: e.regw = 1;
      4'd11: begin e.pcs = 2'b10; e.pcen = 1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic out_t sample();
    out_t a;
    a.st     = bus.state;
    a.alu    = bus.alu_control;
    a.src_a  = bus.alu_src_a;
    a.src_b  = bus.alu_src_b;
    a.ext    = bus.ext_op;
    a.iord   = bus.i_or_d;
    a.irw    = bus.ir_write;
    a.memw   = bus.mem_write;
    a.regw   = bus.reg_write;
    a.regdst = bus.reg_dst;
    a.m2r    = bus.mem_to_reg;
    a.pcen   = bus.pc_en;
    a.pcs    = bus.pc_source;
    a.ill    = bus.illegal;
    return a;
  endfunction

  // Push the expected per-cycle trace of one instruction.
  task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    logic [2:0] ra;
    logic       fok;
    fok = 1'b1;
    case (fn)
      6'b100001: ra = 3'b010;
      6'b100011: ra = 3'b110;
      6'b100100: ra = 3'b000;
      6'b100101: ra = 3'b001;
      default: begin ra = 3'b010; fok = 1'b0; end
    endcase
    exp_q.push_back(exp_state(4'd0, ra, z, 1'b0));
    case (op)
      6'b100011: begin
        exp_q.push_back(exp_state(4'd1, ra, z, 1'b0));
        exp_q.push_back(exp_state(4'd2, ra, z, 1'b0));
        exp_q.push_back(exp_state(4'd3, ra, z, 1'b0));
        exp_q.push_back(exp_state(4'd4, ra, z, 1'b0));
      end
      6'b101011: begin
        exp_q.push_back(exp_state(4'd1, ra, z, 1'b0));
        exp_q.push_back(exp_state(4'd2, ra, z, 1'b0));
        exp_q.push_back(exp_state(4'd5, ra, z, 1'b0));
      end
      6'b000000: begin
        exp_q.push_back(exp_state(4'd1, ra, z, 1'b0));
        exp_q.push_back(exp_state(4'd6, ra, z, ~fok));
        if (fok) exp_q.push_back(exp_state(4'd7, ra, z, 1'b0));
      end
      6'b000100: begin
        exp_q.push_back(exp_state(4'd1, ra, z, 1'b0));
        exp_q.push_back(exp_state(4'd8, ra, z, 1'b0));
      end
      6'b001101: begin
        exp_q.push_back(exp_state(4'd1, ra, z, 1'b0));
        exp_q.push_back(exp_state(4'd9, ra, z, 1'b0));
        exp_q.push_back(exp_state(4'd10, ra, z, 1'b0));
      end
      6'b000010: begin
        exp_q.push_back(exp_state(4'd1, ra, z, 1'b0));
        exp_q.push_back(exp_state(4'd11, ra, z, 1'b0));
      end
      default: exp_q.push_back(exp_state(4'd1, ra, z, 1'b1));
    endcase
  endtask

  // Entered just after a negedge with the DUT in FETCH; leaves the same way.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic z);
    out_t e;
    out_t a;
    int   n;
    bus.op    = op;
    bus.funct = fn;
    bus.zero  = z;
    push_instr(op, fn, z);
    n = 0;
    while (exp_q.size() > 0) begin
      if (n > 0) @(negedge clk);
      #1;
      e = exp_q.pop_front();
      a = sample();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s cycle%0d got=%h expected=%h", name, n, a, e);
      end
      n++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    out_t a;
    reset_n   = 1'b0;
    bus.op    = 6'b111111;
    bus.funct = 6'b000000;
    bus.zero  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    a = sample();
    checks++;
    if (a !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h expected=%h", a, out_t'('0));
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_rtype();
    run_instr("rt_subu", 6'b000000, 6'b100011, 1'b0);
    run_instr("rt_addu", 6'b000000, 6'b100001, 1'b1);
    run_instr("rt_and",  6'b000000, 6'b100100, 1'b0);
    run_instr("rt_or",   6'b000000, 6'b100101, 1'b0);
    run_instr("rt_badfn", 6'b000000, 6'b000111, 1'b0);
  endtask

  task automatic test_mem();
    run_instr("lw", 6'b100011, 6'b000000, 1'b0);
    run_instr("sw", 6'b101011, 6'b111111, 1'b0);
  endtask

  task automatic test_branch();
    run_instr("beq_taken",  6'b000100, 6'b000000, 1'b1);
    run_instr("beq_not",    6'b000100, 6'b000000, 1'b0);
  endtask

  task automatic test_ori_j();
    run_instr("ori", 6'b001101, 6'b100011, 1'b0);
    run_instr("j",   6'b000010, 6'b000000, 1'b1);
  endtask

  task automatic test_illegal();
    run_instr("ill_ff", 6'b111111, 6'b000000, 1'b0);
    run_instr("ill_01", 6'b000001, 6'b100001, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_instr("b2b_lw",  6'b100011, 6'b000000, 1'b0);
    run_instr("b2b_ill", 6'b111110, 6'b000000, 1'b0);
    run_instr("b2b_or",  6'b000000, 6'b100101, 1'b0);
    run_instr("b2b_j",   6'b000010, 6'b000000, 1'b0);
    run_instr("b2b_sw",  6'b101011, 6'b000000, 1'b0);
  endtask

  task automatic test_reset_mid_rtexec();
    out_t a;
    bus.op    = 6'b000000;
    bus.funct = 6'b100011;
    bus.zero  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    a = sample();
    checks++;
    if (a.st !== 4'd6) begin
      failures++;
      $display("FAIL mid_rtexec_state got=%0d expected=6", a.st);
    end
    reset_n = 1'b0;
    #1;
    a = sample();
    checks++;
    if (a !== '0) begin
      failures++;
      $display("FAIL async_reset_outputs got=%h expected=%h", a, out_t'('0));
    end
    @(negedge clk);
    reset_n = 1'b1;
    run_instr("post_reset_lw", 6'b100011, 6'b000000, 1'b0);
  endtask

`ifdef PERF_CNT_EN
  task automatic test_perf();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (retired !== 4'd0) begin
      failures++;
      $display("FAIL retired_reset got=%0d expected=0", retired);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 17; i++) run_instr("perf_j", 6'b000010, 6'b000000, 1'b0);
    checks++;
    if (retired !== 4'd1) begin
      failures++;
      $display("FAIL retired_wrap got=%0d expected=1", retired);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_mem();
    test_branch();
    test_ori_j();
    test_illegal();
    test_back_to_back();
    test_reset_mid_rtexec();
`ifdef PERF_CNT_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
